// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
//   Multi-cycle controller for ARM block transfers (LDM/STM). It walks the
//   16-bit register list one register per memory beat, in ascending register
//   order at ascending word addresses. It then performs the optional base
//   writeback and signals completion.
//
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle request, honoured only when idle
//   code, base    instruction word (P U S W L Rn list) and the value of Rn
//   busy          high while an operation is in progress (through the done cycle)
//   mem_*         single-beat memory port, request held until mem_ack
//   rf_idx        register read (STM) / load target (LDM) of the current beat
//   rf_rdata      combinational register-file read of rf_idx
//   rf_we/waddr/wdata  register write port (load beats and base writeback)
//   user_bank     latched S bit for the whole operation
//   pc_load       pulses with done when an LDM loaded R15
//   done, err     completion pulse; err marks an mem_ack timeout abort
//   ACK_TIMEOUT   waiting cycles per beat before abort (0 = wait forever)
module ldm_stm_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] code,
    input  logic [31:0] base,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  rf_idx,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        user_bank,
    output logic        pc_load,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_XFER, S_WB, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [24:0] code_q, code_d;      // condition/class bits are not needed
    logic [31:0] base_q, base_d;
    logic [15:0] list_q, list_d;      // registers still to transfer
    logic [31:0] addr_q, addr_d;
    logic [31:0] wb_val_q, wb_val_d;
    logic [31:0] wait_q, wait_d;      // waiting cycles of the current beat
    logic        abort_q, abort_d;
    logic        busy_q, busy_d;
    logic        mem_req_q, mem_req_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        pc_load_q, pc_load_d;
    logic        user_bank_q, user_bank_d;

    logic [4:0]  n_regs;
    logic [31:0] four_n;
    logic [3:0]  low_idx;
    logic        load_we, wb_we;

    logic        unused_code;
    assign unused_code = ^code[31:25];

    always_comb begin
        n_regs = '0;
        for (int i = 0; i < 16; i++) begin
            n_regs = n_regs + {4'd0, list_q[i]};
        end
        four_n = {25'd0, n_regs, 2'b00};
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                low_idx = i[3:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        base_d   = base_q;
        list_d   = list_q;
        addr_d   = addr_q;
        wb_val_d = wb_val_q;
        wait_d   = wait_q;
        abort_d  = abort_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    code_d  = code[24:0];
                    base_d  = base;
                    list_d  = code[15:0];
                    abort_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Every mode transfers the same ascending block; only its
                // lowest address depends on P/U.
                case (code_q[24:23])
                    2'b01:   addr_d = base_q;
                    2'b11:   addr_d = base_q + 32'd4;
                    2'b00:   addr_d = base_q - four_n + 32'd4;
                    default: addr_d = base_q - four_n;
                endcase
                wb_val_d = code_q[23] ? base_q + four_n : base_q - four_n;
                wait_d   = '0;
                state_d  = (n_regs == 5'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                if (mem_ack) begin
                    list_d = list_q & ~(16'd1 << low_idx);
                    addr_d = addr_q + 32'd4;
                    wait_d = '0;
                    if (list_d == 16'd0) begin
                        state_d = S_WB;
                    end
                end else if ((ACK_TIMEOUT != 0) && (wait_q == ACK_TIMEOUT - 32'd1)) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered outputs follow the state being entered.
        busy_d      = (state_d != S_IDLE);
        mem_req_d   = (state_d == S_XFER);
        done_d      = (state_d == S_DONE);
        err_d       = (state_d == S_DONE) && abort_d;
        pc_load_d   = (state_d == S_DONE) && !abort_d && code_d[20] && code_d[15];
        user_bank_d = (state_d != S_IDLE) && code_d[22];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            base_q      <= '0;
            list_q      <= '0;
            addr_q      <= '0;
            wb_val_q    <= '0;
            wait_q      <= '0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pc_load_q   <= 1'b0;
            user_bank_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            base_q      <= base_d;
            list_q      <= list_d;
            addr_q      <= addr_d;
            wb_val_q    <= wb_val_d;
            wait_q      <= wait_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pc_load_q   <= pc_load_d;
            user_bank_q <= user_bank_d;
        end
    end

    // Load data and writeback strobes must land in the ack / WB cycle itself.
    // A loaded Rn takes precedence over the writeback value.
    assign load_we = (state_q == S_XFER) && mem_ack && code_q[20];
    assign wb_we   = (state_q == S_WB) && code_q[21] && !(code_q[20] && code_q[code_q[19:16]]);

    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_req_q ? addr_q : 32'd0;
    assign mem_we    = mem_req_q && !code_q[20];
    assign mem_wdata = mem_we ? rf_rdata : 32'd0;
    assign rf_idx    = (state_q == S_XFER) ? low_idx : 4'd0;
    assign rf_we     = load_we || wb_we;
    assign rf_waddr  = load_we ? low_idx : (wb_we ? code_q[19:16] : 4'd0);
    assign rf_wdata  = load_we ? mem_rdata : (wb_we ? wb_val_q : 32'd0);
    assign user_bank = user_bank_q;
    assign pc_load   = pc_load_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
